// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch digit logic.
// Digits are 4-bit unsigned BCD codes packed LSD-first into a flat vector.
package stopwatch_pkg;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Picks digit i out of a vector padded to MAX_DIGITS digits.
    function automatic logic [DIGIT_W-1:0] digit_slice(
        input logic [DIGIT_W*MAX_DIGITS-1:0] v,
        input logic [2:0]                    i
    );
        return v[32'(i)*DIGIT_W +: DIGIT_W];
    endfunction

endpackage

// File: rtl/digit_compare_sequencer.sv
// Serial MSD-first comparison of two BCD time values through one external 4-bit comparator.
// Reports cur >= tgt and cur == tgt with a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start, comparator inputs parked at 0
// CMP   | presenting snapshot digit idx to the comparator, one digit per clock
// DONE  | result decided, done pulses for this single cycle
module digit_compare_sequencer
    import stopwatch_pkg::*;
#(
    parameter int NDIGITS = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [DIGIT_W*NDIGITS-1:0]   cur_digits,
    input  logic [DIGIT_W*NDIGITS-1:0]   tgt_digits,
    output logic [DIGIT_W-1:0]           cmp_a,
    output logic [DIGIT_W-1:0]           cmp_b,
    input  logic                         cmp_ge,
    input  logic                         cmp_eq,
    output logic                         busy,
    output logic                         done,
    output logic                         ge,
    output logic                         eq
);

    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int VW = DIGIT_W * NDIGITS;

    state_t          state, state_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic [VW-1:0]   snap_cur, snap_cur_nxt;
    logic [VW-1:0]   snap_tgt, snap_tgt_nxt;
    logic            busy_nxt, done_nxt, ge_nxt, eq_nxt;

    logic [DIGIT_W*MAX_DIGITS-1:0] cur_ext, tgt_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            snap_cur <= '0;
            snap_tgt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ge       <= 1'b0;
            eq       <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            snap_cur <= snap_cur_nxt;
            snap_tgt <= snap_tgt_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            ge       <= ge_nxt;
            eq       <= eq_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = CMP;
            CMP:     if (!cmp_eq || idx == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs are computed here and captured by the state register.
    always_comb begin
        idx_nxt      = idx;
        snap_cur_nxt = snap_cur;
        snap_tgt_nxt = snap_tgt;
        ge_nxt       = ge;
        eq_nxt       = eq;
        busy_nxt     = (state_nxt != IDLE);
        done_nxt     = (state_nxt == DONE);
        unique case (state)
            IDLE: begin
                if (start) begin
                    snap_cur_nxt = cur_digits;
                    snap_tgt_nxt = tgt_digits;
                    idx_nxt      = IW'(NDIGITS - 1);
                    ge_nxt       = 1'b0;
                    eq_nxt       = 1'b0;
                end
            end
            CMP: begin
                if (!cmp_eq) begin
                    ge_nxt = cmp_ge;
                    eq_nxt = 1'b0;
                end else if (idx == '0) begin
                    ge_nxt = 1'b1;
                    eq_nxt = 1'b1;
                end else begin
                    idx_nxt = idx - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        cur_ext = (DIGIT_W*MAX_DIGITS)'(snap_cur);
        tgt_ext = (DIGIT_W*MAX_DIGITS)'(snap_tgt);
        cmp_a   = '0;
        cmp_b   = '0;
        if (state == CMP) begin
            cmp_a = digit_slice(cur_ext, 3'(idx));
            cmp_b = digit_slice(tgt_ext, 3'(idx));
        end
    end

endmodule

// File: tb/tb_digit_compare_sequencer.sv
// Scoreboard bench for digit_compare_sequencer with the 4-bit comparator modelled alongside.
module tb_digit_compare_sequencer;

    localparam int ND = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [23:0]   cur_digits, tgt_digits;
    logic [3:0]    cmp_a, cmp_b;
    logic          cmp_ge, cmp_eq;
    logic          busy, done, ge, eq;

    digit_compare_sequencer #(.NDIGITS(ND)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cur_digits(cur_digits), .tgt_digits(tgt_digits),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_ge(cmp_ge), .cmp_eq(cmp_eq),
        .busy(busy), .done(done), .ge(ge), .eq(eq)
    );

    assign cmp_ge = (cmp_a >= cmp_b);
    assign cmp_eq = (cmp_a == cmp_b);

    always #5 clk = ~clk;

    typedef struct {
        logic ge;
        logic eq;
        int   lat;
        int   start_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result_ge", int'(ge), int'(e.ge));
                check("result_eq", int'(eq), int'(e.eq));
                check("latency", cyc - e.start_cyc, e.lat);
            end
        end
    end

    task automatic issue(input logic [23:0] c, input logic [23:0] t,
                         input int k, input logic g, input logic q, input logic expect_done);
        exp_t e;
        @(negedge clk);
        cur_digits = c;
        tgt_digits = t;
        start      = 1'b1;
        e.ge = g; e.eq = q; e.lat = k + 1; e.start_cyc = cyc;
        if (expect_done) exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got still busy after %0d cycles, expected idle", name, n);
            exp_q.delete();
        end
    endtask

    task automatic run_case(input string name, input logic [23:0] c, input logic [23:0] t,
                            input int k, input logic g, input logic q);
        issue(c, t, k, g, q, 1'b1);
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy"}, int'(busy), 1);
        wait_idle(name);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cur_digits = '0; tgt_digits = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", int'({busy, done, ge, eq, cmp_a, cmp_b}), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_cmp_parked", int'({cmp_a, cmp_b}), 0);

        run_case("equal",        24'h123456, 24'h123456, 6, 1'b1, 1'b1);
        check("hold_ge", int'(ge), 1);
        check("hold_eq", int'(eq), 1);
        run_case("gt_digit4",    24'h130000, 24'h125959, 2, 1'b1, 1'b0);
        run_case("lt_lsd",       24'h123455, 24'h123456, 6, 1'b0, 1'b0);
        run_case("gt_msd",       24'h200000, 24'h195959, 1, 1'b1, 1'b0);
        run_case("lt_msd",       24'h090000, 24'h100000, 1, 1'b0, 1'b0);
        run_case("gt_lsd",       24'h000001, 24'h000000, 6, 1'b1, 1'b0);

        // Start retriggered mid-compare and during DONE must be ignored.
        issue(24'h123456, 24'h123456, 6, 1'b1, 1'b1, 1'b1);
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        begin
            int n;
            n = 0;
            while (done !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("retrig_done_seen", int'(done), 1);
        end
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        check("retrig_idle", int'(busy), 0);

        // Inputs changing after acceptance must not affect the result.
        issue(24'h123456, 24'h123456, 6, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        start = 1'b0;
        cur_digits = 24'h000000;
        wait_idle("snapshot");
        @(negedge clk);

        // Reset mid-compare aborts with no done pulse.
        issue(24'h123455, 24'h123456, 6, 1'b0, 1'b0, 1'b0);
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("abort_outputs", int'({busy, done, ge, eq, cmp_a, cmp_b}), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        run_case("after_abort",  24'h130000, 24'h125959, 2, 1'b1, 1'b0);

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish before 100000");
        $fatal(1);
    end

endmodule
